mesh_result_drain: RTL
======================

# mesh_result_drain

Downstream consumer of the sorting mesh. When the mesh controller signals that sorting has finished, this block snapshots every PE's `nanci_result` word in a single cycle. It then streams the words out in slot order over a valid/ready interface. While streaming it checks each word's address tag, flag bit and sort order, so the top level and benches get a single pass/fail verdict per run.

## Interface
Parameters:
- `N`, 4: number of PEs (result slots); must be ≥ 2.
- `ADDR_WIDTH`, 2: slot address field width; `2**ADDR_WIDTH` ≥ N.
- `DATA_WIDTH`, 32: payload width.
- `DESCENDING`, 1: 1 = slot k+1 must be ≤ slot k; 0 = slot k+1 must be ≥ slot k. Comparison is unsigned.
- Derived `WIDTH` = ADDR_WIDTH + DATA_WIDTH. Each result word is WIDTH+1 bits: {flag, addr, data}.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sort_done`  in  1: one-cycle pulse from the mesh controller; results are final in the same cycle.
- `in_results`  in  N*(WIDTH+1): flattened PE results. Slot k occupies bits [(k+1)*(WIDTH+1)-1 : k*(WIDTH+1)].
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: consumer accepts the word.
- `out_addr`  out  ADDR_WIDTH: address field of the current word.
- `out_data`  out  DATA_WIDTH: data field of the current word.
- `out_last`  out  1: high with slot N-1.
- `busy`  out  1: high in STREAM.
- `done`  out  1: one-cycle pulse after the last handshake.
- `tag_err`  out  1: a word's flag ≠ 0 or its addr ≠ its slot index.
- `order_err`  out  1: an adjacent pair violates the `DESCENDING` rule.
- `overrun`  out  1: `sort_done` arrived while not IDLE.

## Operation
- States are IDLE, STREAM and DONE, with a slot counter `idx` of width clog2(N).
- IDLE → STREAM:
  - Taken when `sort_done`=1.
  - On that edge, all N slots are latched into an internal buffer, `idx` is set to 0, and `tag_err` and `order_err` are cleared.
- STREAM:
  - `out_valid`=1.
  - `out_addr` and `out_data` come from `buffer[idx]`.
  - `out_last` = (idx == N-1).
- A handshake occurs when `out_valid` && `out_ready`. On each handshake:
  - If idx < N-1, `idx` increments.
  - If idx = N-1, the state moves to DONE.
- Checks, evaluated on each handshake of slot idx:
  - `tag_err` is set if `flag[idx]`=1 or `addr[idx]` ≠ idx.
  - `order_err` is set if idx > 0 and `data[idx]` vs `data[idx-1]` violates the ordering rule. Equal values are legal.
  - Both errors are sticky until the next capture or `rst`.
- DONE: `done`=1 for exactly one cycle, then unconditional return to IDLE.
- `sort_done` in STREAM or DONE:
  - It is ignored: no recapture, and the buffer is unchanged.
  - `overrun` is set, sticky until `rst`.
- `in_results` is only sampled on the capture edge. Later changes have no effect on the current run.

## Timing
- Reset values: state IDLE, `idx`=0, and `out_valid`, `out_last`, `busy`, `done`, `tag_err`, `order_err`, `overrun` all 0. `out_addr` and `out_data` are 0 (driven from the buffer, which resets to 0).
- Latency: `sort_done` at edge t gives `out_valid`=1 with slot 0 from cycle t+1.
- Throughput: one word per cycle with `out_ready` held high. The last handshake occurs at cycle t+N, `done` is high in cycle t+N+1, and the block is IDLE at t+N+2.
- While `out_valid` && !`out_ready`, `out_addr`, `out_data` and `out_last` hold stable. `out_valid` never drops before its handshake.
- `tag_err` and `order_err` become visible the cycle after the offending handshake.
- `sort_done` in the DONE cycle counts as an overrun. It is not queued.
- `rst` mid-STREAM: the next cycle is IDLE with all outputs at reset values. Partial streams are not resumed.
- `rst` and `sort_done` in the same cycle: `rst` wins and nothing is captured.
- `out_ready` in IDLE or DONE has no effect.

## Test plan
- Clean run: N=4, slots k = {flag 0, addr k, data 3-k}, `out_ready`=1, pulse `sort_done`.
  - Expect outputs (0,3), (1,2), (2,1), (3,0) on four consecutive cycles, `out_last` on the 4th, and `done` on the next cycle.
  - Expect `tag_err`=`order_err`=`overrun`=0.
- Backpressure: same data, `out_ready` toggling 0,0,1,0,1,1,0,1.
  - Each word is held stable until accepted; exactly 4 handshakes occur; the order is unchanged.
- Tag error: slot 2 has addr=1 (separately, a second run with slot 1 flag=1).
  - `tag_err`=1 after that slot's handshake and stays 1 through `done`. The next clean capture clears it.
- Order error: data {3,1,2,0} with DESCENDING=1.
  - `order_err` rises after slot 2's handshake.
  - Data {3,3,1,1} produces no error.
- Overrun: `sort_done` again while streaming slot 1 with changed `in_results`.
  - `overrun`=1, and the remaining outputs still come from the original capture.
- Reset mid-stream: assert `rst` during slot 2 with `out_ready`=0.
  - The next cycle shows `out_valid`=0, `busy`=0, and all flags 0.
  - A new `sort_done` then streams a fresh run correctly.

Source files
------------

// File: rtl/mesh_result_drain.sv
// Captures every PE result word in one cycle, then streams the words out in slot order over valid/ready.
// Each word's tag and the sort order are checked as it is streamed, giving one pass/fail verdict per run.
module mesh_result_drain #(
    parameter  int N          = 4,
    parameter  int ADDR_WIDTH = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int DESCENDING = 1,
    localparam int WIDTH      = ADDR_WIDTH + DATA_WIDTH,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sort_done,
    input  logic [N*(WIDTH+1)-1:0]    in_results,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      tag_err,
    output logic                      order_err,
    output logic                      overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH:0]      buf_q [N];
    logic [WIDTH:0]      buf_d [N];
    logic                tag_q, tag_d;
    logic                order_q, order_d;
    logic                overrun_q, overrun_d;

    logic                hs;
    logic [WIDTH:0]      cur_word;
    logic [WIDTH:0]      prev_word;
    logic [DATA_WIDTH-1:0] cur_data, prev_data;
    logic                bad_order;

    assign hs        = (state_q == S_STREAM) && out_ready;
    assign cur_word  = buf_q[idx_q];
    // Only consulted when idx_q > 0, so the wrap at idx_q == 0 is harmless.
    assign prev_word = buf_q[idx_q - IDX_W'(1)];
    assign cur_data  = cur_word[DATA_WIDTH-1:0];
    assign prev_data = prev_word[DATA_WIDTH-1:0];
    assign bad_order = (DESCENDING != 0) ? (cur_data > prev_data) : (cur_data < prev_data);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        order_d   = order_q;
        overrun_d = overrun_q;
        for (int k = 0; k < N; k++) begin
            buf_d[k] = buf_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (sort_done) begin
                    for (int k = 0; k < N; k++) begin
                        buf_d[k] = in_results[k*(WIDTH+1) +: (WIDTH+1)];
                    end
                    idx_d   = '0;
                    tag_d   = 1'b0;
                    order_d = 1'b0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (hs) begin
                    if (cur_word[WIDTH] || (cur_word[WIDTH-1:DATA_WIDTH] != ADDR_WIDTH'(idx_q))) begin
                        tag_d = 1'b1;
                    end
                    if ((idx_q != '0) && bad_order) begin
                        order_d = 1'b1;
                    end
                    if (idx_q == IDX_W'(N-1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sort_done && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tag_q     <= 1'b0;
            order_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            order_q   <= order_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    assign out_valid = (state_q == S_STREAM);
    assign busy      = (state_q == S_STREAM);
    assign done      = (state_q == S_DONE);
    assign out_last  = (state_q == S_STREAM) && (idx_q == IDX_W'(N-1));
    assign out_addr  = cur_word[WIDTH-1:DATA_WIDTH];
    assign out_data  = cur_word[DATA_WIDTH-1:0];
    assign tag_err   = tag_q;
    assign order_err = order_q;
    assign overrun   = overrun_q;

endmodule
